// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM states and round helper functions
package aes_pkg;

  localparam int NR    = 10;
  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of a block sits at bits [127-8k -: 8]; out(r,c) = in(r,(c+r) mod 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box lookup
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 occupies the top byte, so entry a starts at bit 8*(255-a).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_cipher_iter.sv
// rtl/aes_cipher_iter.sv - iterative AES-128 encryption core, one round per clock
module aes_cipher_iter #(
  parameter int NR    = 10,
  parameter int BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_block,
  output logic [3:0]       rk_idx,
  input  logic [BLK_W-1:0] rk,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_block,
  output logic             busy
);
  import aes_pkg::fsm_t;
  import aes_pkg::ST_IDLE;
  import aes_pkg::ST_ROUND;
  import aes_pkg::ST_DONE;
  import aes_pkg::shift_rows;
  import aes_pkg::mix_column;

  fsm_t             fsm;
  logic [BLK_W-1:0] state;
  logic [3:0]       round;
  logic [BLK_W-1:0] sb;
  logic [BLK_W-1:0] sr;
  logic [BLK_W-1:0] mc;
  logic [BLK_W-1:0] rnd_out;
  logic             last_round;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a(state[8*i +: 8]),
      .y(sb[8*i +: 8])
    );
  end

  assign sr = shift_rows(sb);

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
    end
  end

  // The final round skips MixColumns.
  assign last_round = (round == 4'(NR));
  assign rnd_out    = (last_round ? sr : mc) ^ rk;
  assign rk_idx     = round;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= ST_IDLE;
      state     <= '0;
      round     <= '0;
      out_valid <= 1'b0;
      out_block <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (in_valid) begin
            state    <= in_block ^ rk;
            round    <= 4'd1;
            fsm      <= ST_ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_ROUND: begin
          state <= rnd_out;
          if (last_round) begin
            round     <= '0;
            fsm       <= ST_DONE;
            out_valid <= 1'b1;
            out_block <= rnd_out;
          end else begin
            round <= round + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            fsm       <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb/tb_aes_cipher_iter.sv - directed-vector bench for aes_cipher_iter
module tb_aes_cipher_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic         busy;

  logic         key_sel = 1'b0;
  logic [127:0] rkb [0:15];
  logic [127:0] rkc [0:15];
  logic [127:0] ecb_pt [0:3];
  logic [127:0] ecb_ct [0:3];

  int total = 0;
  int bad = 0;

  localparam logic [127:0] B_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_E0 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] B_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  assign rk = key_sel ? rkc[rk_idx] : rkb[rk_idx];

  aes_cipher_iter dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_block(in_block),
    .rk_idx(rk_idx),
    .rk(rk),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_block(out_block),
    .busy(busy)
  );

  initial begin
    for (int i = 0; i < 16; i++) begin
      rkb[i] = '0;
      rkc[i] = '0;
    end
    rkb[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rkb[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rkb[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rkb[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rkb[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rkb[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rkb[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rkb[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rkb[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rkb[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rkb[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rkc[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rkc[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rkc[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rkc[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rkc[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rkc[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rkc[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rkc[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rkc[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rkc[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rkc[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    ecb_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    ecb_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    ecb_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    ecb_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    ecb_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    ecb_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    ecb_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
    ecb_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
  end

  // Presents a block and returns at the negedge after the accept edge.
  task automatic send(input logic [127:0] pt, output bit ok);
    int n;
    n = 0;
    in_block = pt;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, busy, rk_idx} !== 6'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got valid=%0b busy=%0b rk_idx=%0d want 0 0 0", out_valid, busy, rk_idx);
    end
    total++;
    if (out_block !== 128'd0) begin
      bad++;
      $display("FAIL reset_block: got %h want 0", out_block);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_fips_b;
    bit ok;
    int c;
    key_sel = 1'b0;
    out_ready = 1'b1;
    send(B_PT, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b_accept: got in_ready=0 want 1");
    end
    total++;
    if (dut.state !== B_E0) begin
      bad++;
      $display("FAIL b_state_e0: got %h want %h", dut.state, B_E0);
    end
    wait_out(c);
    total++;
    if (c !== 10) begin
      bad++;
      $display("FAIL b_latency: got %0d want 10", c);
    end
    total++;
    if (out_block !== B_CT) begin
      bad++;
      $display("FAIL b_cipher: got %h want %h", out_block, B_CT);
    end
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL b_release: got valid=%0b in_ready=%0b busy=%0b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_fips_c;
    key_sel = 1'b1;
    out_ready = 1'b1;
    in_block = C_PT;
    in_valid = 1'b1;
    total++;
    if ({in_ready, rk_idx} !== 5'b1_0000) begin
      bad++;
      $display("FAIL c_rk_idx_0: got ready=%0b rk_idx=%0d want 1 0", in_ready, rk_idx);
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (rk_idx !== 4'(k)) begin
        bad++;
        $display("FAIL c_rk_idx_%0d: got %0d want %0d", k, rk_idx, k);
      end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_block !== C_CT) begin
      bad++;
      $display("FAIL c_cipher: got valid=%0b %h want 1 %h", out_valid, out_block, C_CT);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit ok;
    int c;
    key_sel = 1'b0;
    out_ready = 1'b0;
    send(ecb_pt[0], ok);
    wait_out(c);
    total++;
    if (c !== 10 || out_block !== ecb_ct[0]) begin
      bad++;
      $display("FAIL bp_first: got lat=%0d %h want 10 %h", c, out_block, ecb_ct[0]);
    end
    in_block = ecb_pt[1];
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, busy} !== 3'b101 || out_block !== ecb_ct[0]) begin
        bad++;
        $display("FAIL bp_hold_%0d: got valid=%0b in_ready=%0b busy=%0b %h want 1 0 1 %h",
                 k, out_valid, in_ready, busy, out_block, ecb_ct[0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release: got valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_next_accept: got busy=%0b want 1", busy);
    end
    wait_out(c);
    total++;
    if (out_block !== ecb_ct[1]) begin
      bad++;
      $display("FAIL bp_second: got %h want %h", out_block, ecb_ct[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int c;
    key_sel = 1'b0;
    out_ready = 1'b1;
    send(B_PT, ok);
    repeat (3) @(negedge clk);
    total++;
    if (rk_idx !== 4'd4) begin
      bad++;
      $display("FAIL rm_round: got %0d want 4", rk_idx);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, busy} !== 2'b00 || out_block !== 128'd0) begin
      bad++;
      $display("FAIL rm_cleared: got valid=%0b busy=%0b %h want 0 0 0", out_valid, busy, out_block);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL rm_idle: got in_ready=%0b valid=%0b want 1 0", in_ready, out_valid);
    end
    send(B_PT, ok);
    wait_out(c);
    total++;
    if (c !== 10 || out_block !== B_CT) begin
      bad++;
      $display("FAIL rm_rerun: got lat=%0d %h want 10 %h", c, out_block, B_CT);
    end
    @(negedge clk);
  endtask

  task automatic test_input_ignore;
    bit ok;
    bit seen_busy;
    int c;
    key_sel = 1'b0;
    out_ready = 1'b1;
    send(B_PT, ok);
    c = 0;
    while (!out_valid && c < 40) begin
      in_valid = ~in_valid;
      in_block = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    total++;
    if (c !== 10 || out_block !== B_CT) begin
      bad++;
      $display("FAIL ig_cipher: got lat=%0d %h want 10 %h", c, out_block, B_CT);
    end
    seen_busy = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (busy || out_valid) seen_busy = 1'b1;
    end
    total++;
    if (seen_busy !== 1'b0) begin
      bad++;
      $display("FAIL ig_second_accept: got activity=1 want 0");
    end
  endtask

  task automatic test_back_to_back;
    int n_in;
    int n_out;
    int cyc;
    bit acc;
    bit ho;
    bit extra;
    key_sel = 1'b0;
    n_in = 0;
    n_out = 0;
    cyc = 0;
    while (n_out < 4 && cyc < 600) begin
      in_valid = (n_in < 4);
      in_block = (n_in < 4) ? ecb_pt[n_in] : 128'd0;
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      ho = out_valid && out_ready;
      if (ho) begin
        total++;
        if (out_block !== ecb_ct[n_out]) begin
          bad++;
          $display("FAIL b2b_block_%0d: got %h want %h", n_out, out_block, ecb_ct[n_out]);
        end
        n_out++;
      end
      if (acc) n_in++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (n_out !== 4 || n_in !== 4) begin
      bad++;
      $display("FAIL b2b_count: got in=%0d out=%0d want 4 4", n_in, n_out);
    end
    extra = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) extra = 1'b1;
    end
    total++;
    if (extra !== 1'b0) begin
      bad++;
      $display("FAIL b2b_duplicate: got extra out_valid=1 want 0");
    end
  endtask

  initial begin
    test_reset();
    test_fips_b();
    test_fips_c();
    test_backpressure();
    test_reset_mid();
    test_input_ignore();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
